// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone B4 pipelined master: one core request at a time,
// finished by a one-cycle response pulse carrying either ACK data or a timeout abort.
module wishbone_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_timeout_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] to_cnt;
  logic        stb_taken;
  logic        done;
  logic        expire;

  // An ack only counts once the strobe has actually been accepted; an ack
  // under stall is a slave protocol error and is dropped.
  assign stb_taken = (state == REQUEST) && !wb_stall_i;
  assign done      = (stb_taken && wb_ack_i) || ((state == WAIT_ACK) && wb_ack_i);
  assign expire    = TO_EN && (to_cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      to_cnt        <= '0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_timeout_o <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_sel_o      <= '0;
      wb_stb_o      <= 1'b0;
      wb_cyc_o      <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            wb_adr_o    <= req_adr_i;
            wb_dat_o    <= req_dat_i;
            wb_we_o     <= req_we_i;
            wb_sel_o    <= req_sel_i;
            wb_stb_o    <= 1'b1;
            wb_cyc_o    <= 1'b1;
            req_ready_o <= 1'b0;
            to_cnt      <= '0;
            state       <= REQUEST;
          end
        end
        REQUEST, WAIT_ACK: begin
          if (done) begin
            // Ready rises with the response so the next request can be
            // taken in the response cycle.
            rsp_valid_o   <= 1'b1;
            rsp_dat_o     <= wb_dat_i;
            rsp_timeout_o <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_cyc_o      <= 1'b0;
            req_ready_o   <= 1'b1;
            state         <= IDLE;
          end else if (expire) begin
            rsp_valid_o   <= 1'b1;
            rsp_dat_o     <= '0;
            rsp_timeout_o <= 1'b1;
            wb_stb_o      <= 1'b0;
            wb_cyc_o      <= 1'b0;
            req_ready_o   <= 1'b1;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (stb_taken) begin
              wb_stb_o <= 1'b0;
              state    <= WAIT_ACK;
            end
          end
        end
        default: begin
          wb_stb_o <= 1'b0;
          wb_cyc_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wishbone_master.md
# wishbone_master

Single-outstanding Wishbone B4 pipelined-mode master for the processor's memory ports: the initiator side of the bus that the testbench slave models answer. It accepts one read or write request per handshake from a core-side valid/ready interface and drives the STB/CYC cycle, honouring STALL. It returns the ACK'd data, or a timeout indication, as a single-cycle response pulse.

## Interface
- TIMEOUT_CYCLES, default 256: cycles a transaction may stay open (from first STB cycle) before abort; 0 disables timeout; legal range 0..65535.
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  core request present
- req_ready_o  out  1  master can accept a request this cycle
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  32  byte address
- req_dat_i  in  32  write data
- req_sel_i  in  4  byte lane select
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  32  read data (valid with rsp_valid_o)
- rsp_timeout_o  out  1  response is a timeout abort (valid with rsp_valid_o)
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  bus write data
- wb_dat_i  in  32  bus read data
- wb_we_o  out  1  bus write enable
- wb_sel_o  out  4  bus byte select
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_stall_i  in  1  slave not accepting strobe
- wb_ack_i  in  1  slave acknowledge

## Operation
- States: IDLE, REQUEST, WAIT_ACK. Reset state IDLE.
- IDLE: req_ready_o=1. If req_valid_i at an edge, register adr/dat/we/sel into wb_*_o, clear timeout counter, go to REQUEST.
- REQUEST: wb_stb_o=1, wb_cyc_o=1. At an edge with wb_stall_i=0 the strobe is accepted:
  - wb_ack_i=1 in the same cycle: complete, go to IDLE.
  - wb_ack_i=0: go to WAIT_ACK.
  - wb_stall_i=1: stay. wb_ack_i is ignored while stalled (protocol violation, no completion).
- WAIT_ACK: wb_stb_o=0, wb_cyc_o=1. wb_stall_i is ignored. On wb_ack_i=1: complete, go to IDLE.
- Completion: at the same edge, rsp_dat_o<=wb_dat_i (reads and writes alike), rsp_timeout_o<=0, rsp_valid_o<=1 for exactly one cycle.
- Timeout: a 16-bit counter increments every cycle in REQUEST/WAIT_ACK. When TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES-1 without a completing ack:
  - go to IDLE with wb_stb_o=wb_cyc_o=0 next cycle;
  - rsp_valid_o=1, rsp_timeout_o=1, rsp_dat_o=0.
  - An ack on the expiry edge wins (normal completion).
- wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o hold their registered values until the next request is accepted.
- rsp_dat_o and rsp_timeout_o hold until the next response.
- Reset values: req_ready_o=0 during reset, then 1 in IDLE. All other outputs 0.
- Reset mid-transaction: next edge returns to IDLE with stb/cyc low. No response is issued and the counter is cleared.

## Timing
- Request accepted at edge E0. wb_stb_o/wb_cyc_o are high from E0 through the accepting edge.
- Zero stall, ack one cycle after accept: STB high one cycle (E0..E1), ack sampled E2, rsp_valid_o high E2..E3, total 2 cycles from request to response.
- Ack in the accept cycle: response one cycle earlier.
- Each stall cycle adds one cycle.
- Back-to-back: req_ready_o is high in the same cycle rsp_valid_o is high. The next request can be accepted then, giving a minimum of 2 cycles per transaction with zero-cycle ack.
- wb_cyc_o never drops between strobe and ack except on timeout or reset.

## Test plan
- Read, no stall, ack 1 cycle after accept, wb_dat_i=0xDEADBEEF, adr=0x1000 -> one STB cycle with wb_adr_o=0x1000, wb_we_o=0; rsp_valid_o one cycle with rsp_dat_o=0xDEADBEEF, rsp_timeout_o=0.
- Write adr=0x20, dat=0x12345678, sel=0xF, wb_stall_i high for 3 cycles -> STB held 4 cycles with stable adr/dat/we=1/sel; ack -> single rsp_valid_o pulse; req_ready_o low throughout.
- Ack asserted while stall high, then stall drops with no ack, ack 2 cycles later -> first ack ignored; exactly one response, at the later ack.
- TIMEOUT_CYCLES=8, slave never acks -> cyc/stb drop after 8 cycles; rsp_valid_o=1, rsp_timeout_o=1, rsp_dat_o=0; next request accepted normally.
- Three back-to-back reads with zero-cycle ack -> each response 1 cycle after its STB; new request accepted in each rsp_valid_o cycle; no gap in CYC ownership errors.
- rst_i asserted in WAIT_ACK -> next cycle cyc/stb=0, rsp_valid_o=0, req_ready_o=1 after reset release; late ack is ignored.
